namco_ctl_latch: RTL and testbench

Parametrised control-latch and interrupt block for the Namco 6809 boards. It replaces the fixed per-function register logic with a generic addressable latch bank (LS259-style) that both the main and sub CPU can write. It adds edge-triggered VBLANK interrupt pending flags per CPU and an optional frame watchdog. It runs in the MCLK domain, uses a CPU clock-enable, and feeds the CPU cores, IO controller and WSG sound block.

---
 rtl/namco_ctl_latch.sv | 135 +++++++++++++
 tb/tb_namco_ctl_latch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/namco_ctl_latch.sv
// Addressable control latch bank shared by main/sub 6809s, VBLANK IRQ flags, optional frame watchdog (WATCHDOG_EN).
// Latency: latch write 1 MCLK; VBLANK edge to IRQ 3 MCLK; watchdog pulse 1 MCLK after the limit edge, 16 MCLK wide.
// Backpressure: none; writes are fire-and-forget, qualified by CPU_CEN, and are never stalled.
module namco_ctl_latch #(
  parameter int                  LATCH_AW    = 3,
  parameter int                  NUM_LATCH   = 2**LATCH_AW,
  parameter logic [15:0]         M_BASE      = 16'h5000,
  parameter logic [15:0]         S_BASE      = 16'h2000,
  parameter logic [NUM_LATCH-1:0] S_WR_MASK  = NUM_LATCH'(8'b0010_1001),
  parameter int                  IDX_SIRQ    = 0,
  parameter int                  IDX_MIRQ    = 1,
  parameter int                  IDX_SND     = 3,
  parameter int                  IDX_IORST   = 4,
  parameter int                  IDX_SRST    = 5,
  parameter int                  WDOG_FRAMES = 8,
  parameter logic [15:0]         WDOG_BASE   = 16'h8000
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  input  logic                 CPU_CEN,
  input  logic [15:0]          M_ADRS,
  input  logic                 M_VMA,
  input  logic                 M_WE,
  input  logic [15:0]          S_ADRS,
  input  logic                 S_VMA,
  input  logic                 S_WE,
  input  logic                 VBLANK,
  output logic [NUM_LATCH-1:0] LATCH,
  output logic                 M_IRQ,
  output logic                 S_IRQ,
  output logic                 SND_EN,
  output logic                 IO_RESET,
  output logic                 S_RESET,
  output logic                 WD_RESET
);

  logic [NUM_LATCH-1:0] latch_q;
  logic [NUM_LATCH-1:0] latch_nxt;
  logic [LATCH_AW-1:0]  m_idx;
  logic [LATCH_AW-1:0]  s_idx;
  logic                 m_hit;
  logic                 s_hit;
  logic [2:0]           vb_sr;
  logic                 vb_rise;
  logic                 m_pend;
  logic                 s_pend;
  logic                 wd_active;

  // Address decode: window match on the upper bits, index in the middle, data in bit 0.
  assign m_idx = M_ADRS[LATCH_AW:1];
  assign s_idx = S_ADRS[LATCH_AW:1];
  assign m_hit = CPU_CEN & M_VMA & M_WE & (M_ADRS[15:LATCH_AW+1] == M_BASE[15:LATCH_AW+1]);
  assign s_hit = CPU_CEN & S_VMA & S_WE & (S_ADRS[15:LATCH_AW+1] == S_BASE[15:LATCH_AW+1])
               & S_WR_MASK[s_idx];

  // Next latch value: sub is applied last so it wins a same-index collision; watchdog wipes all.
  always_comb begin
    latch_nxt = latch_q;
    if (m_hit) latch_nxt[m_idx] = M_ADRS[0];
    if (s_hit) latch_nxt[s_idx] = S_ADRS[0];
    if (wd_active) latch_nxt = '0;
  end

  // Latch bank register.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) latch_q <= '0;
    else       latch_q <= latch_nxt;
  end

  // VBLANK two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) vb_sr <= 3'b000;
    else       vb_sr <= {vb_sr[1:0], VBLANK};
  end

  assign vb_rise = vb_sr[1] & ~vb_sr[2];

  // Pending flags: a disabled enable (acknowledge) dominates a coincident edge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      m_pend <= 1'b0;
      s_pend <= 1'b0;
    end else if (wd_active) begin
      m_pend <= 1'b0;
      s_pend <= 1'b0;
    end else begin
      m_pend <= latch_q[IDX_MIRQ] & (m_pend | vb_rise);
      s_pend <= latch_q[IDX_SIRQ] & (s_pend | vb_rise);
    end
  end

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_FRAMES + 1);

  logic [WDW-1:0] wd_cnt;
  logic [4:0]     wd_tmr;
  logic           wd_kick;
  logic           wd_limit;

  assign wd_kick   = CPU_CEN & M_VMA & M_WE & (M_ADRS[15:11] == WDOG_BASE[15:11]);
  assign wd_limit  = (wd_cnt == WDOG_FRAMES[WDW-1:0]);
  assign wd_active = (wd_tmr != 5'd0);

  // Frame counter and 16-cycle reset pulse; the counter is held clear while the pulse runs.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
      wd_tmr <= 5'd0;
    end else if (wd_active) begin
      wd_cnt <= '0;
      wd_tmr <= wd_tmr - 5'd1;
    end else begin
      if (wd_limit) wd_tmr <= 5'd16;
      if (wd_kick)                   wd_cnt <= '0;
      else if (vb_rise && !wd_limit) wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  assign WD_RESET = wd_active;
`else
  logic unused_wdog;

  assign unused_wdog = ^{WDOG_BASE, WDOG_FRAMES};
  assign wd_active   = 1'b0;
  assign WD_RESET    = 1'b0;
`endif

  assign LATCH    = latch_q;
  assign M_IRQ    = m_pend;
  assign S_IRQ    = s_pend;
  assign SND_EN   = latch_q[IDX_SND];
  assign IO_RESET = ~latch_q[IDX_IORST];
  assign S_RESET  = ~latch_q[IDX_SRST];

endmodule

// File: tb/tb_namco_ctl_latch.sv
// Bench for namco_ctl_latch: directed scenarios plus randomized bus/VBLANK traffic.
// Outputs are compared every falling edge against a behavioural model; literal checks pin key cases.
// Inputs are driven 1 time unit after the rising edge.
module tb_namco_ctl_latch;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CPU_CEN = 1'b0;
  logic [15:0] M_ADRS = 16'h0;
  logic        M_VMA = 1'b0;
  logic        M_WE = 1'b0;
  logic [15:0] S_ADRS = 16'h0;
  logic        S_VMA = 1'b0;
  logic        S_WE = 1'b0;
  logic        VBLANK = 1'b0;
  logic [7:0]  LATCH;
  logic        M_IRQ;
  logic        S_IRQ;
  logic        SND_EN;
  logic        IO_RESET;
  logic        S_RESET;
  logic        WD_RESET;

  int errors = 0;
  int checks = 0;
  int wd_hi  = 0;

  namco_ctl_latch dut (
    .MCLK(MCLK), .RESET(RESET), .CPU_CEN(CPU_CEN),
    .M_ADRS(M_ADRS), .M_VMA(M_VMA), .M_WE(M_WE),
    .S_ADRS(S_ADRS), .S_VMA(S_VMA), .S_WE(S_WE),
    .VBLANK(VBLANK), .LATCH(LATCH), .M_IRQ(M_IRQ), .S_IRQ(S_IRQ),
    .SND_EN(SND_EN), .IO_RESET(IO_RESET), .S_RESET(S_RESET), .WD_RESET(WD_RESET)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] ml;          // latch bits
  bit       mp_m, mp_s;  // pending flags
  bit [2:0] vh;          // VBLANK as seen at the last three clock edges, [0] newest
  int       wcnt, wtmr;  // frames since kick, remaining watchdog pulse cycles

  task automatic model_reset();
    ml = 8'h0; mp_m = 0; mp_s = 0; vh = 3'b0; wcnt = 0; wtmr = 0;
  endtask

  task automatic model_step();
    bit [7:0] smask;
    bit [7:0] nl;
    bit       rise, nm, ns, kick;
    smask = 8'b0010_1001;
    nl    = ml;
    // a rising edge is "high two samples ago, low three samples ago"
    rise  = vh[1] && !vh[2];
    if (CPU_CEN && M_VMA && M_WE && M_ADRS[15:4] == 12'h500) nl[M_ADRS[3:1]] = M_ADRS[0];
    if (CPU_CEN && S_VMA && S_WE && S_ADRS[15:4] == 12'h200 && smask[S_ADRS[3:1]])
      nl[S_ADRS[3:1]] = S_ADRS[0];
    nm = ml[1] ? (mp_m || rise) : 1'b0;
    ns = ml[0] ? (mp_s || rise) : 1'b0;
    kick = CPU_CEN && M_VMA && M_WE && M_ADRS[15:11] == 5'b10000;
`ifdef WATCHDOG_EN
    if (wtmr > 0) begin
      nl = 8'h0; nm = 0; ns = 0; wcnt = 0; wtmr = wtmr - 1;
    end else begin
      if (wcnt == 8) wtmr = 16;
      if (kick)                  wcnt = 0;
      else if (rise && wcnt < 8) wcnt = wcnt + 1;
    end
`else
    if (kick) wcnt = 0;
`endif
    vh   = {vh[1:0], VBLANK};
    ml   = nl;
    mp_m = nm;
    mp_s = ns;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge MCLK or posedge RESET);
      if (RESET) model_reset();
      else       model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge MCLK);
      chk("cyc_latch",  32'(LATCH),    32'(ml));
      chk("cyc_mirq",   32'(M_IRQ),    32'(mp_m));
      chk("cyc_sirq",   32'(S_IRQ),    32'(mp_s));
      chk("cyc_snd",    32'(SND_EN),   32'(ml[3]));
      chk("cyc_iorst",  32'(IO_RESET), 32'(!ml[4]));
      chk("cyc_srst",   32'(S_RESET),  32'(!ml[5]));
      chk("cyc_wdrst",  32'(WD_RESET), 32'(wtmr > 0));
      if (WD_RESET) wd_hi++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic mw(input logic [15:0] a);
    M_ADRS = a; M_VMA = 1'b1; M_WE = 1'b1;
    tick();
    M_VMA = 1'b0; M_WE = 1'b0;
  endtask

  task automatic sw(input logic [15:0] a);
    S_ADRS = a; S_VMA = 1'b1; S_WE = 1'b1;
    tick();
    S_VMA = 1'b0; S_WE = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    RESET = 1'b1;
    M_VMA = 0; M_WE = 0; S_VMA = 0; S_WE = 0; VBLANK = 0; CPU_CEN = 0;
    repeat (2) tick();
    RESET = 1'b0;
    CPU_CEN = 1'b1;
    tick();
  endtask

  task automatic vb_frame();
    VBLANK = 1'b1;
    repeat (3) tick();
    VBLANK = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [15:0] rand_addr(input logic [15:0] base);
    logic [15:0] a;
    int r;
    r = $urandom_range(0, 39);
    if (r < 24)      a = base | 16'($urandom_range(0, 15));
    else if (r == 0) a = 16'h8000 | 16'($urandom_range(0, 16'h07ff));
    else             a = 16'($urandom);
    return a;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int vb_left;
    repeat (2) tick();
    chk("rst_latch", 32'(LATCH), 32'h0);
    chk("rst_iorst", 32'(IO_RESET), 32'h1);
    chk("rst_srst",  32'(S_RESET), 32'h1);
    chk("rst_irq",   32'({M_IRQ, S_IRQ}), 32'h0);
    chk("rst_wd",    32'(WD_RESET), 32'h0);
    RESET = 1'b0;
    CPU_CEN = 1'b1;
    tick();

    // main writes release sub CPU then IO chip
    mw(16'h500B);
    chk("srst_rel", 32'(S_RESET), 32'h0);
    mw(16'h5009);
    chk("iorst_rel", 32'(IO_RESET), 32'h0);
    chk("latch_30", 32'(LATCH), 32'h30);
    chk("model_30", 32'(ml), 32'h30);

    // sub writes: permitted index 3, masked index 2
    sw(16'h2007);
    chk("snd_en", 32'(SND_EN), 32'h1);
    sw(16'h2005);
    chk("masked_idx2", 32'(LATCH[2]), 32'h0);

    // same-index collision: sub value wins
    M_ADRS = 16'h5006; M_VMA = 1; M_WE = 1;
    S_ADRS = 16'h2007; S_VMA = 1; S_WE = 1;
    tick();
    M_VMA = 0; M_WE = 0; S_VMA = 0; S_WE = 0;
    chk("collide_sub", 32'(LATCH[3]), 32'h1);

    // main IRQ: enable, VBLANK edge, hold, acknowledge
    mw(16'h5003);
    VBLANK = 1'b1;
    repeat (2) tick();
    chk("mirq_early", 32'(M_IRQ), 32'h0);
    tick();
    chk("mirq_set", 32'(M_IRQ), 32'h1);
    VBLANK = 1'b0;
    repeat (5) tick();
    chk("mirq_hold", 32'(M_IRQ), 32'h1);
    mw(16'h5002);
    tick();
    chk("mirq_ack", 32'(M_IRQ), 32'h0);
    VBLANK = 1'b1;
    repeat (2) tick();
    VBLANK = 1'b0;
    repeat (4) tick();
    chk("mirq_dis_edge", 32'(M_IRQ), 32'h0);

    // edge coincides with the cycle the disable is visible: clear wins
    mw(16'h5003);
    VBLANK = 1'b1;
    tick();
    M_ADRS = 16'h5002; M_VMA = 1; M_WE = 1;
    tick();
    M_VMA = 0; M_WE = 0;
    repeat (3) tick();
    chk("mirq_coincide", 32'(M_IRQ), 32'h0);
    VBLANK = 1'b0;
    repeat (2) tick();

    // sub IRQ through sub-writable index 0
    sw(16'h2001);
    VBLANK = 1'b1;
    repeat (3) tick();
    chk("sirq_set", 32'(S_IRQ), 32'h1);
    VBLANK = 1'b0;
    sw(16'h2000);
    tick();
    chk("sirq_ack", 32'(S_IRQ), 32'h0);

    // reset mid-frame discards the edge in flight
    mw(16'h5003);
    VBLANK = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    chk("midrst_irq", 32'(M_IRQ), 32'h0);
    VBLANK = 1'b0;
    tick();
    RESET = 1'b0;
    mw(16'h5003);
    repeat (4) tick();
    chk("midrst_noedge", 32'(M_IRQ), 32'h0);

    // randomized traffic
    vb_left = 20;
    for (int i = 0; i < 3000; i++) begin
      CPU_CEN = ($urandom_range(0, 3) != 0);
      M_VMA   = $urandom_range(0, 1) == 1;
      M_WE    = $urandom_range(0, 1) == 1;
      M_ADRS  = rand_addr(16'h5000);
      S_VMA   = $urandom_range(0, 1) == 1;
      S_WE    = $urandom_range(0, 1) == 1;
      S_ADRS  = rand_addr(16'h2000);
      if (vb_left == 0) begin
        VBLANK  = ~VBLANK;
        vb_left = VBLANK ? $urandom_range(1, 12) : $urandom_range(5, 40);
      end else begin
        vb_left--;
      end
      tick();
    end
    M_VMA = 0; M_WE = 0; S_VMA = 0; S_WE = 0; VBLANK = 0; CPU_CEN = 1;
    repeat (25) tick();

`ifdef WATCHDOG_EN
    // no kicks: exactly 16 cycles of WD_RESET after the 8th edge, latch wiped
    do_reset();
    mw(16'h500B);
    wd_hi = 0;
    repeat (8) vb_frame();
    repeat (40) tick();
    chk("wd_pulse_len", 32'(wd_hi), 32'd16);
    chk("wd_latch_clr", 32'(LATCH), 32'h0);

    // kick every 4 frames: never fires
    do_reset();
    wd_hi = 0;
    for (int f = 0; f < 5; f++) begin
      repeat (4) vb_frame();
      mw(16'h8000);
    end
    repeat (40) tick();
    chk("wd_kicked", 32'(wd_hi), 32'd0);
`else
    do_reset();
    wd_hi = 0;
    repeat (10) vb_frame();
    repeat (20) tick();
    chk("wd_tied_off", 32'(wd_hi), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
